jellyvl_etherneco_packet_tx: RTL and testbench
==============================================

Name: jellyvl_etherneco_packet_tx

Overview:
Master-side ring-bus packet framer. It builds one etherneco packet per request: 4-byte header, then payload bytes pulled from a streaming source, then an optional 4-byte FCS. The framed byte stream goes to the PHY-side tx channel, the same first/last/data/valid/ready format the slave nodes forward on their down/up links. It is the upstream producer of the packets that slave packet receivers parse into length/type/node/payload.

Parameters:
FCS_ENABLE, 1'b1, append CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF, final xor 0xFFFFFFFF) over the payload bytes only.
LENGTH_WIDTH, 16, width of tx_length; the payload byte count is tx_length+1.

Ports:
reset  input  1  asynchronous, active-low reset.
clk  input  1  clock; all logic on the rising edge.
tx_start  input  1  request pulse; sampled only when busy=0.
tx_length  input  LENGTH_WIDTH  payload bytes minus 1; latched on an accepted start.
tx_type  input  8  packet type; latched on an accepted start.
tx_node  input  8  destination/initial node field; latched on an accepted start.
busy  output  1  high from the accepted start until the last byte handshakes.
tx_done  output  1  one-cycle pulse on the cycle the last byte handshakes.
s_payload_data  input  8  payload byte.
s_payload_valid  input  1  payload byte valid.
s_payload_ready  output  1  payload byte accepted.
m_tx_first  output  1  marks the first byte of the packet.
m_tx_last  output  1  marks the final byte of the packet.
m_tx_data  output  8  framed byte.
m_tx_valid  output  1  byte valid.
m_tx_ready  input  1  downstream accept.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, tx_done=0, m_tx_valid=0, m_tx_first=0, m_tx_last=0, m_tx_data=0, s_payload_ready=0; CRC register=0xFFFFFFFF.
- Frame byte order:
  - node, type, length[7:0], length[15:8] (zero-extend if LENGTH_WIDTH<16);
  - payload[0..tx_length];
  - FCS[7:0], [15:8], [23:16], [31:24], i.e. the standard Ethernet FCS byte order.
- States: IDLE, HEADER (byte index 0..3), PAYLOAD (byte counter), FCS (index 0..3). The state machine is the sole source of framing; there are no other modes.
- IDLE: tx_start=1 latches the fields, sets busy, enters HEADER and presents header byte 0 with m_tx_valid=1 and m_tx_first=1 on the next cycle. Start-to-first-valid latency is exactly 1 cycle.
- Output is registered, AXI-stream style:
  - A byte completes when m_tx_valid && m_tx_ready.
  - While m_tx_valid=1 and m_tx_ready=0, data/first/last hold stable.
  - valid is never withdrawn without a handshake.
  - Back-to-back bytes are issued with no bubble while m_tx_ready=1.
- PAYLOAD:
  - s_payload_ready = (output register empty or being consumed this cycle) && state==PAYLOAD && payload bytes remaining.
  - Each accepted payload byte enters the output register and updates the CRC in the same cycle.
  - If the source underruns (s_payload_valid=0), m_tx_valid drops once the register drains; no filler byte is inserted.
- m_tx_last is set on the final FCS byte. With FCS_ENABLE=0 it is set on the final payload byte and FCS is skipped.
- The CRC register is reinitialised to 0xFFFFFFFF on every accepted start.
- On the last handshake: tx_done=1 for one cycle, busy=0, return to IDLE.
- tx_start while busy=1 is ignored, with no queuing.
- tx_start in the same cycle as tx_done is ignored; busy is still 1 in that cycle.
- tx_length=0: exactly one payload byte. tx_length=all-ones: 65536 payload bytes; the counter must not wrap early.
- An asserted reset mid-packet aborts immediately. No m_tx_last is emitted; the downstream receiver treats the truncated frame as an error.

Decomposition:
- Shared package jellyvl_etherneco_pkg holds:
  - header size constant (4) and FCS size constant (4);
  - CRC-32 polynomial (0xEDB88320 reflected), init and final-xor constants;
  - state enum typedef.
- One sub-module: jellyvl_etherneco_crc32_byte. It is a combinational byte-wise CRC-32 next-state function, also reusable by packet_rx for FCS checking.

Test Plan:
1. Basic frame: FCS_ENABLE=1, node=0x01, type=0x10, length=8, payload "123456789" (0x31..0x39), m_tx_ready=1 constant.
   - Expected stream: 01 10 08 00 31..39 26 39 F4 CB, 17 bytes.
   - first on 0x01, last on 0xCB, tx_done once, no bubbles.
2. Backpressure: same packet, m_tx_ready toggles with a 3-cycles-low/1-high pattern.
   - Identical byte sequence; data stable while stalled; exactly 17 handshakes.
3. Minimum length: length=0, payload 0x00, FCS_ENABLE=0.
   - Stream: node, type, 00, 00, 00 with last on the 5th byte.
   - s_payload_ready accepts exactly 1 byte.
4. Source underrun: s_payload_valid low for 5 cycles mid-payload.
   - m_tx_valid gaps; no duplicated or dropped byte; FCS is still 0xCBF43926 for the case-1 payload.
5. Ignored start: tx_start pulsed during HEADER and on the tx_done cycle.
   - Only one packet is sent; busy=0 afterwards; a subsequent start then sends a new packet.
6. Reset mid-PAYLOAD (reset=0 for 2 cycles).
   - All outputs return to reset values asynchronously; no m_tx_last.
   - The next packet's FCS is correct, confirming the CRC was reinitialised.

Source files
------------

// File: rtl/jellyvl_etherneco_pkg.sv
// Purpose: shared constants and types for the etherneco packet framer/parser.
// Latency: n/a (package only).
// Backpressure: n/a.
package jellyvl_etherneco_pkg;

  localparam int HEADER_SIZE = 4;
  localparam int FCS_SIZE    = 4;

  // CRC-32 IEEE 802.3, reflected form.
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_FCS
  } tx_state_t;

endpackage

// File: rtl/jellyvl_etherneco_crc32_byte.sv
// Purpose: combinational byte-wise CRC-32 next-state (reflected, LSB first).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register crc_out.
// Ports: crc_in  - current CRC register value
//        data    - byte being folded into the CRC
//        crc_out - CRC register value after absorbing data
module jellyvl_etherneco_crc32_byte
  import jellyvl_etherneco_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/jellyvl_etherneco_packet_tx.sv
// Purpose: ring-bus packet framer: 4-byte header, streamed payload, optional CRC-32 FCS.
// Latency: first framed byte valid 1 cycle after an accepted tx_start; no bubbles while m_tx_ready=1.
// Backpressure: registered valid/ready output; s_payload_ready only when the output slot frees.
// Ports: reset/clk               - async active-low reset, rising-edge clock
//        tx_start/length/type/node - request and header fields (latched when idle)
//        busy/tx_done            - packet in flight / last byte handshake pulse
//        s_payload_*             - byte stream source for the payload
//        m_tx_*                  - framed byte stream towards the PHY side
module jellyvl_etherneco_packet_tx
  import jellyvl_etherneco_pkg::*;
#(
  parameter bit FCS_ENABLE   = 1'b1,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    reset,
  input  logic                    clk,

  input  logic                    tx_start,
  input  logic [LENGTH_WIDTH-1:0] tx_length,
  input  logic [7:0]              tx_type,
  input  logic [7:0]              tx_node,
  output logic                    busy,
  output logic                    tx_done,

  input  logic [7:0]              s_payload_data,
  input  logic                    s_payload_valid,
  output logic                    s_payload_ready,

  output logic                    m_tx_first,
  output logic                    m_tx_last,
  output logic [7:0]              m_tx_data,
  output logic                    m_tx_valid,
  input  logic                    m_tx_ready
);

  tx_state_t               state, state_n;
  // Index of the next header/FCS byte to load; in FCS, value 4 means all loaded.
  logic [2:0]              idx, idx_n;
  // Payload bytes still to accept, minus one; pay_left clears after the final one,
  // so an all-ones length runs the full range without wrapping early.
  logic [LENGTH_WIDTH-1:0] cnt, cnt_n;
  logic                    pay_left, pay_left_n;
  logic [LENGTH_WIDTH-1:0] len_r, len_n;
  logic [7:0]              type_r, type_n;
  logic [7:0]              node_r, node_n;
  logic [31:0]             crc, crc_n;
  logic [31:0]             crc_calc;

  logic                    out_vld, vld_n;
  logic [7:0]              out_dat, dat_n;
  logic                    out_first, first_n;
  logic                    out_last, last_n;

  logic                    can_load;
  logic                    hs_last;
  logic [15:0]             len16;
  logic [31:0]             fcs;

  jellyvl_etherneco_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (s_payload_data),
    .crc_out (crc_calc)
  );

  // Output slot is free if empty or being consumed this cycle.
  assign can_load        = !out_vld || m_tx_ready;
  assign hs_last         = out_vld && m_tx_ready && out_last;
  assign len16           = 16'(len_r);
  assign fcs             = crc ^ CRC32_XOR;

  assign busy            = (state != ST_IDLE);
  assign tx_done         = hs_last;
  assign s_payload_ready = can_load && (state == ST_PAYLOAD) && pay_left;
  assign m_tx_valid      = out_vld;
  assign m_tx_data       = out_dat;
  assign m_tx_first      = out_first;
  assign m_tx_last       = out_last;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    pay_left_n = pay_left;
    len_n      = len_r;
    type_n     = type_r;
    node_n     = node_r;
    crc_n      = crc;
    vld_n      = out_vld && !m_tx_ready;
    dat_n      = out_dat;
    first_n    = out_first;
    last_n     = out_last;

    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          len_n      = tx_length;
          type_n     = tx_type;
          node_n     = tx_node;
          cnt_n      = tx_length;
          pay_left_n = 1'b1;
          crc_n      = CRC32_INIT;
          idx_n      = 3'd1;
          state_n    = ST_HEADER;
          vld_n      = 1'b1;
          dat_n      = tx_node;
          first_n    = 1'b1;
          last_n     = 1'b0;
        end
      end

      ST_HEADER: begin
        if (can_load) begin
          vld_n   = 1'b1;
          first_n = 1'b0;
          last_n  = 1'b0;
          case (idx)
            3'd1:    dat_n = type_r;
            3'd2:    dat_n = len16[7:0];
            default: dat_n = len16[15:8];
          endcase
          if (idx == 3'(HEADER_SIZE - 1)) begin
            state_n = ST_PAYLOAD;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (pay_left) begin
          if (s_payload_ready && s_payload_valid) begin
            vld_n   = 1'b1;
            dat_n   = s_payload_data;
            first_n = 1'b0;
            last_n  = !FCS_ENABLE && (cnt == '0);
            crc_n   = crc_calc;
            if (cnt == '0) begin
              pay_left_n = 1'b0;
              if (FCS_ENABLE) begin
                state_n = ST_FCS;
                idx_n   = 3'd0;
              end
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end else if (hs_last) begin
          state_n = ST_IDLE;
        end
      end

      ST_FCS: begin
        if (idx < 3'(FCS_SIZE)) begin
          if (can_load) begin
            vld_n   = 1'b1;
            first_n = 1'b0;
            last_n  = (idx == 3'(FCS_SIZE - 1));
            case (idx[1:0])
              2'd0:    dat_n = fcs[7:0];
              2'd1:    dat_n = fcs[15:8];
              2'd2:    dat_n = fcs[23:16];
              default: dat_n = fcs[31:24];
            endcase
            idx_n = idx + 3'd1;
          end
        end else if (hs_last) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      pay_left  <= 1'b0;
      len_r     <= '0;
      type_r    <= 8'h00;
      node_r    <= 8'h00;
      crc       <= CRC32_INIT;
      out_vld   <= 1'b0;
      out_dat   <= 8'h00;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      pay_left  <= pay_left_n;
      len_r     <= len_n;
      type_r    <= type_n;
      node_r    <= node_n;
      crc       <= crc_n;
      out_vld   <= vld_n;
      out_dat   <= dat_n;
      out_first <= first_n;
      out_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_tx.sv
module tb_jellyvl_etherneco_packet_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_t, start_x;
  logic        sel;
  logic [15:0] tx_length;
  logic [7:0]  tx_type, tx_node;
  logic [7:0]  s_payload_data;
  logic        s_payload_valid;
  logic        m_tx_ready;

  logic        busy0, done0, pr0, first0, last0, vld0;
  logic [7:0]  data0;
  logic        busy1, done1, pr1, first1, last1, vld1;
  logic [7:0]  data1;

  logic        start_any, start0, start1;
  assign start_any = start_t | start_x;
  assign start0    = start_any & ~sel;
  assign start1    = start_any & sel;

  // Instance 0: FCS on.  Instance 1: FCS off.  sel picks which one is driven and observed.
  jellyvl_etherneco_packet_tx #(.FCS_ENABLE(1'b1), .LENGTH_WIDTH(16)) u_dut0 (
    .reset(reset), .clk(clk),
    .tx_start(start0), .tx_length(tx_length), .tx_type(tx_type), .tx_node(tx_node),
    .busy(busy0), .tx_done(done0),
    .s_payload_data(s_payload_data), .s_payload_valid(s_payload_valid), .s_payload_ready(pr0),
    .m_tx_first(first0), .m_tx_last(last0), .m_tx_data(data0), .m_tx_valid(vld0),
    .m_tx_ready(m_tx_ready)
  );

  jellyvl_etherneco_packet_tx #(.FCS_ENABLE(1'b0), .LENGTH_WIDTH(16)) u_dut1 (
    .reset(reset), .clk(clk),
    .tx_start(start1), .tx_length(tx_length), .tx_type(tx_type), .tx_node(tx_node),
    .busy(busy1), .tx_done(done1),
    .s_payload_data(s_payload_data), .s_payload_valid(s_payload_valid), .s_payload_ready(pr1),
    .m_tx_first(first1), .m_tx_last(last1), .m_tx_data(data1), .m_tx_valid(vld1),
    .m_tx_ready(m_tx_ready)
  );

  logic       busy, tx_done, s_payload_ready, m_tx_first, m_tx_last, m_tx_valid;
  logic [7:0] m_tx_data;
  assign busy            = sel ? busy1  : busy0;
  assign tx_done         = sel ? done1  : done0;
  assign s_payload_ready = sel ? pr1    : pr0;
  assign m_tx_first      = sel ? first1 : first0;
  assign m_tx_last       = sel ? last1  : last0;
  assign m_tx_valid      = sel ? vld1   : vld0;
  assign m_tx_data       = sel ? data1  : data0;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay_all[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  int   cyc = 0, start_cyc = 0, done_cyc = 0;
  int   rdy_mode = 0, stall_at = -1, stall_left = 0;
  logic src_rand = 1'b0;
  logic start_on_done = 1'b0;
  int   hs_cnt = 0, acc_cnt = 0, done_cnt = 0, last_cnt = 0;
  logic prev_stall = 1'b0, prev_first = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  typedef struct {
    logic        s;
    logic [7:0]  node;
    logic [7:0]  typ;
    int          len;
    int          pat;       // 0: 0x31.. ascending, 1: zeros
    int          mode;      // m_tx_ready pattern
    int          st_at;     // stall source after this many accepted bytes
    int          st_len;
    logic        chk_lat;
    logic        chk_fcs;
    logic [31:0] exp_fcs;
    int          exp_bytes;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-32 (reflected IEEE) over the current payload.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay_all[i]) begin
      c = c ^ {24'h0, pay_all[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // One cycle: drive sink ready and source valid on the falling edge, then observe.
  task automatic tick();
    logic stall;
    @(negedge clk);
    cyc++;
    start_x = 1'b0;
    case (rdy_mode)
      1:       m_tx_ready = ((cyc % 4) == 3);
      2:       m_tx_ready = ($urandom_range(0, 9) < 7);
      default: m_tx_ready = 1'b1;
    endcase
    stall = 1'b0;
    if (stall_left > 0 && acc_cnt == stall_at) begin
      stall = 1'b1;
      stall_left--;
    end
    if (src_rand && $urandom_range(0, 9) < 3) stall = 1'b1;
    if (src_q.size() > 0 && !stall) begin
      s_payload_valid = 1'b1;
      s_payload_data  = src_q[0];
    end else begin
      s_payload_valid = 1'b0;
      s_payload_data  = 8'hEE;
    end
    #1;
    if (reset) begin
      if (s_payload_valid && s_payload_ready) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      if (prev_stall) begin
        checks++;
        if (!(m_tx_valid && m_tx_data == prev_dat && m_tx_first == prev_first && m_tx_last == prev_last)) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%0h f=%0b l=%0b expected v=1 d=%0h f=%0b l=%0b",
                   m_tx_valid, m_tx_data, m_tx_first, m_tx_last, prev_dat, prev_first, prev_last);
        end
      end
      if (m_tx_valid && m_tx_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %0h expected no byte", m_tx_data);
        end else begin
          logic [7:0] e;
          logic ef, el;
          e  = exp_q.pop_front();
          ef = (hs_cnt == 1);
          el = (exp_q.size() == 0);
          if (m_tx_data != e || m_tx_first != ef || m_tx_last != el) begin
            errors++;
            $display("FAIL stream_byte %0d: got d=%0h f=%0b l=%0b expected d=%0h f=%0b l=%0b",
                     hs_cnt - 1, m_tx_data, m_tx_first, m_tx_last, e, ef, el);
          end
        end
        cap_q.push_back(m_tx_data);
        if (m_tx_last) last_cnt++;
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (start_on_done) begin
          start_x       = 1'b1;
          start_on_done = 1'b0;
        end
      end
      prev_stall = m_tx_valid && !m_tx_ready;
      prev_dat   = m_tx_data;
      prev_first = m_tx_first;
      prev_last  = m_tx_last;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic prep(input logic s, input logic [7:0] node, input logic [7:0] typ, input int len,
                      input int mode, input int st_at, input int st_len, input logic srand);
    logic [15:0] l16;
    logic [31:0] f;
    l16        = 16'(len);
    sel        = s;
    tx_node    = node;
    tx_type    = typ;
    tx_length  = l16;
    rdy_mode   = mode;
    stall_at   = st_at;
    stall_left = st_len;
    src_rand   = srand;
    src_q      = pay_all;
    exp_q.delete();
    cap_q.delete();
    exp_q.push_back(node);
    exp_q.push_back(typ);
    exp_q.push_back(l16[7:0]);
    exp_q.push_back(l16[15:8]);
    foreach (pay_all[i]) exp_q.push_back(pay_all[i]);
    if (!s) begin
      f = ref_crc();
      exp_q.push_back(f[7:0]);
      exp_q.push_back(f[15:8]);
      exp_q.push_back(f[23:16]);
      exp_q.push_back(f[31:24]);
    end
    hs_cnt = 0; acc_cnt = 0; done_cnt = 0; last_cnt = 0;
  endtask

  task automatic start_packet();
    tick();
    #1;
    start_t   = 1'b1;
    start_cyc = cyc;
    tick();
    #1;
    start_t = 1'b0;
    chk("first_latency", {m_tx_valid, m_tx_first, m_tx_data}, {1'b1, 1'b1, tx_node});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("done_within_budget", (done_cnt != 0), 1);
    tick();
    tick();
  endtask

  task automatic post(input int exp_bytes, input int len, input logic chk_fcs, input logic [31:0] exp_fcs,
                      input logic chk_lat);
    chk("handshakes", hs_cnt, exp_bytes);
    chk("payload_accepts", acc_cnt, len + 1);
    chk("done_pulses", done_cnt, 1);
    chk("last_count", last_cnt, 1);
    chk("busy_after", {busy, m_tx_valid}, 0);
    if (chk_fcs && cap_q.size() >= 4)
      chk("fcs_value", {cap_q[cap_q.size()-1], cap_q[cap_q.size()-2], cap_q[cap_q.size()-3],
                        cap_q[cap_q.size()-4]}, exp_fcs);
    if (chk_lat) chk("no_bubble_cycles", done_cyc - start_cyc, exp_bytes);
  endtask

  task automatic fill_ascii(input int len);
    pay_all.delete();
    for (int i = 0; i <= len; i++) pay_all.push_back(8'(8'h31 + i));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start_t = 1'b0; start_x = 1'b0; sel = 1'b0;
    tx_length = 16'h0; tx_type = 8'h0; tx_node = 8'h0;
    s_payload_data = 8'h0; s_payload_valid = 1'b0; m_tx_ready = 1'b1;

    vecs[0] = '{1'b0, 8'h01, 8'h10, 8, 0, 0, -1, 0, 1'b1, 1'b1, 32'hCBF43926, 17};
    vecs[1] = '{1'b0, 8'h01, 8'h10, 8, 0, 1, -1, 0, 1'b0, 1'b1, 32'hCBF43926, 17};
    vecs[2] = '{1'b1, 8'h22, 8'h33, 0, 1, 0, -1, 0, 1'b1, 1'b0, 32'h0, 5};
    vecs[3] = '{1'b0, 8'h01, 8'h10, 8, 0, 0, 4, 5, 1'b0, 1'b1, 32'hCBF43926, 17};

    repeat (3) tick();
    #1;
    chk("reset_state", {busy0, done0, pr0, first0, last0, vld0, data0, busy1, vld1, pr1},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    reset = 1'b1;
    tick();

    // Table-driven packets: basic, backpressure, minimum length, source underrun.
    for (int v = 0; v < 4; v++) begin
      pay_all.delete();
      for (int i = 0; i <= vecs[v].len; i++)
        pay_all.push_back(vecs[v].pat == 0 ? 8'(8'h31 + i) : 8'h00);
      prep(vecs[v].s, vecs[v].node, vecs[v].typ, vecs[v].len, vecs[v].mode,
           vecs[v].st_at, vecs[v].st_len, 1'b0);
      start_packet();
      wait_done();
      post(vecs[v].exp_bytes, vecs[v].len, vecs[v].chk_fcs, vecs[v].exp_fcs, vecs[v].chk_lat);
    end

    // Starts while busy: one during the header, one on the tx_done cycle.
    fill_ascii(8);
    prep(1'b0, 8'h01, 8'h10, 8, 0, -1, 0, 1'b0);
    start_packet();
    tick();
    #1;
    tx_node = 8'hAA;
    start_t = 1'b1;
    tick();
    #1;
    start_t = 1'b0;
    start_on_done = 1'b1;
    wait_done();
    repeat (4) tick();
    #1;
    post(17, 8, 1'b1, 32'hCBF43926, 1'b0);
    chk("ignored_start_flag_used", start_on_done, 0);
    fill_ascii(8);
    prep(1'b0, 8'h05, 8'h10, 8, 0, -1, 0, 1'b0);
    start_packet();
    wait_done();
    post(17, 8, 1'b1, 32'hCBF43926, 1'b1);

    // Reset in the middle of the payload, then a clean packet.
    fill_ascii(8);
    prep(1'b0, 8'h01, 8'h10, 8, 0, -1, 0, 1'b0);
    start_packet();
    begin
      int n;
      n = 0;
      while (acc_cnt < 3 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("reached_payload", (acc_cnt >= 3), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, tx_done, s_payload_ready, m_tx_first, m_tx_last, m_tx_valid, m_tx_data},
        {7'b0, 8'h00});
    tick();
    tick();
    chk("no_last_on_abort", last_cnt, 0);
    #1;
    reset = 1'b1;
    tick();
    fill_ascii(8);
    prep(1'b0, 8'h01, 8'h10, 8, 0, -1, 0, 1'b0);
    start_packet();
    wait_done();
    post(17, 8, 1'b1, 32'hCBF43926, 1'b1);

    // Randomized packets against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic s;
      int   len;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 40);
      pay_all.delete();
      for (int i = 0; i <= len; i++) pay_all.push_back(8'($urandom_range(0, 255)));
      prep(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), len, 2, -1, 0, 1'b1);
      start_packet();
      wait_done();
      post(len + 5 + (s ? 0 : 4), len, !s, ref_crc(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
